// File: rtl/spdma_rdq.sv
// Read-return queue on the RSP DMA drain path: a small circular buffer between
// the DMEM/IMEM read side and the RDRAM write side, with all outputs registered.
module spdma_rdq #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CW-1:0]    count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;

    logic             push_s;
    logic             pop_s;
    logic             clear_s;
    logic [AW-1:0]    wr_ptr_next_s;
    logic [AW-1:0]    rd_ptr_next_s;
    logic [CW-1:0]    count_next_s;
    logic [WIDTH-1:0] head_next_s;

    // Handshakes are qualified only by registered state, so neither ready feeds the other port.
    assign push_s  = in_valid & in_ready_r;
    assign pop_s   = out_valid_r & out_ready;
    assign clear_s = reset | flush;

    // Next pointer/count values and the word that will sit at the head after this edge.
    always_comb begin
        wr_ptr_next_s = wr_ptr_r;
        rd_ptr_next_s = rd_ptr_r;
        count_next_s  = count_r;
        head_next_s   = {WIDTH{1'b0}};

        if (push_s) begin
            wr_ptr_next_s = wr_ptr_r + AW'(1);
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end

        if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + AW'(1);
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end

        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase

        // A word landing in the slot the read pointer will address becomes the new head.
        if (count_next_s == {CW{1'b0}}) begin
            head_next_s = {WIDTH{1'b0}};
        end else if (push_s && (wr_ptr_r == rd_ptr_next_s)) begin
            head_next_s = in_data;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // Storage write; contents are don't-care after a clear, so no reset is applied here.
    always_ff @(posedge clk) begin
        if (push_s && !clear_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // Pointer, count and registered output state.
    always_ff @(posedge clk) begin
        if (clear_s) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= {CW{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
        end else begin
            wr_ptr_r    <= wr_ptr_next_s;
            rd_ptr_r    <= rd_ptr_next_s;
            count_r     <= count_next_s;
            in_ready_r  <= (count_next_s != CW'(DEPTH));
            out_valid_r <= (count_next_s != {CW{1'b0}});
            out_data_r  <= head_next_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign count     = count_r;

endmodule

// File: doc/spdma_rdq.md
Name: spdma_rdq

Overview:
Read-return queue on the RSP DMA path. It accepts words read from DMEM/IMEM on a valid/ready producer port and delivers them to the RDRAM-write side on a valid/ready consumer port. This is the drain side of the DMA datapath, paired with the existing fill-side registers. Storage is a small circular buffer. Output and ready are derived only from registered state, so there is no combinational path from either port's ready to the other port.

Parameters:
WIDTH, 64, data word width in bits
DEPTH, 4, number of entries; must be a power of 2 and at least 2
CW, 3, count width, equal to log2(DEPTH)+1

Ports:
clk  input  1  single clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous queue clear; discards all entries
in_valid  input  1  producer presents in_data
in_data  input  WIDTH  producer data word
in_ready  output  1  queue can accept a word this cycle
out_valid  output  1  out_data holds a valid word
out_data  output  WIDTH  head-of-queue word
out_ready  input  1  consumer accepts out_data this cycle
count  output  CW  number of occupied entries, 0..DEPTH

Behaviour:
- Reset (reset=1 at a clock edge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - out_valid=0, out_data=0, in_ready=1 (after the edge).
  - Storage contents are don't-care.
  - Reset overrides flush, push and pop in the same cycle.
- Flush (reset=0, flush=1): same state result as reset. It has priority over a push or pop in the same cycle; any word offered that cycle is dropped.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It is a function of registered count only and is never combinationally dependent on out_ready. When full, a simultaneous pop does not allow a push that cycle.
- out_valid = (count != 0).
- out_data = mem[rd_ptr] when out_valid=1, otherwise forced to 0.
- Latency: a word pushed at edge N is visible on out_data/out_valid after edge N; it can be popped at edge N+1 at the earliest. There is no same-cycle bypass.
- Count update on each edge:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
  - neither: unchanged
- Pointers wrap modulo DEPTH. The write pointer increments on push and the read pointer on pop.
- Ordering is strict FIFO: no reordering and no duplication.
- Stall: while out_valid=1 and out_ready=0, out_data stays stable. A push in this state writes mem[wr_ptr] only and never disturbs the head entry.
- Empty with in_valid=1: the word is written and out_valid rises after the edge.
- Overflow: in_valid=1 with in_ready=0 is ignored. No state changes and there is no error flag; the producer must hold the word.
- Underflow: out_ready=1 with out_valid=0 is ignored.
- X-safety: in_data is not sampled unless push=1.

Test Plan:
- Reset and idle: assert reset for 2 cycles with in_valid=1 -> count=0, out_valid=0, out_data=0, in_ready=1; no word is accepted during reset.
- Fill to full: push 0x11, 0x22, 0x33, 0x44 on consecutive cycles with out_ready=0 -> count goes 1, 2, 3, 4; in_ready=0 after the 4th edge; out_data=0x11 throughout; a 5th offer of 0x55 is ignored and count stays 4.
- Drain with wrap: continuing from full, assert out_ready for 4 cycles while pushing 0x55..0x58 only once in_ready=1 -> output sequence is 0x11, 0x22, 0x33, 0x44, then 0x55...; pointers wrap with no loss or duplication.
- Simultaneous push/pop at count=2: count stays 2 and output order is preserved. At count=4 with out_ready=1 and in_valid=1: the pop occurs, the push does not, and count becomes 3.
- Stall stability: with out_valid=1 and out_ready=0 for 5 cycles while pushing 2 words -> out_data stays constant at the head value and count increases by 2.
- Flush mid-stream: at count=3, assert flush with in_valid=1 and out_ready=1 -> count=0 and out_valid=0 the next cycle; neither word is consumed or stored. A subsequent push of 0xAB appears as the head one cycle later.
